register_pipe: RTL
==================

// Module: register_pipe
// PURPOSE
//  Parametrised successor to the 4-bit resettable register.
//  - DEPTH-stage elastic pipeline of WIDTH-bit registers with a valid/ready handshake on both sides.
//  - Adds a synchronous flush and an occupancy count.
//  - Used as the generic retiming/decoupling stage between datapath blocks.
// PARAMETERS
//  WIDTH      4    data width in bits (>=1)
//  DEPTH      2    number of register stages (>=1)
//  RESET_VAL  '0   value loaded into every data register on rst/clr
// PORTS
//  clk        in   1        single clock, all state on posedge clk
//  rst        in   1        asynchronous, active-high reset (always_ff @(posedge clk, posedge rst))
//  clr        in   1        synchronous flush, active-high
//  in_valid   in   1        upstream data valid
//  in_ready   out  1        block can accept in_data this cycle
//  in_data    in   WIDTH    upstream data
//  out_valid  out  1        out_data valid; registered, from last stage
//  out_ready  in   1        downstream accepts out_data
//  out_data   out  WIDTH    data from last stage; registered
//  count      out  CW       items held; CW=$clog2(CAP+1); CAP=DEPTH (2*DEPTH with skid)
// BEHAVIOUR
//  - Reset (rst=1, async):
//    - all stage valids=0; data=RESET_VAL
//    - out_valid=0, out_data=RESET_VAL, count=0
//    - in_ready=1 (0 when REGISTER_PIPE_SKID_EN and rst asserted)
//  - Transfer rules:
//    - Input transfer: in_valid&in_ready at posedge. Output transfer: out_valid&out_ready at posedge.
//    - in_data/in_valid must be held stable while in_valid&!in_ready; the block never drops or duplicates an item.
//    - Ordering is strict FIFO.
//  - Stage k (0=input side): v[k], d[k]. Stage ready r[k] = !v[k] | r[k+1]; r[DEPTH] = out_ready; in_ready = r[0] & !clr.
//    - r[k] & v[k-1] (v[-1]=in_valid) -> d[k]<=d[k-1], v[k]<=1.
//    - Else, if r[k+1] -> v[k]<=0.
//  - Latency: DEPTH cycles from input transfer to out_valid on an empty pipe. Throughput 1 item/cycle when out_ready held high.
//  - Bubbles collapse: a stalled output lets upstream stages keep filling until full (count==CAP, in_ready=0).
//  - Full and out_ready=1: input and output transfer in the same cycle; count unchanged.
//  - Empty: out_valid=0; out_data holds last value (not re-zeroed).
//  - count: +1 on input transfer, -1 on output transfer, unchanged when both/neither. Never exceeds CAP, never wraps.
//  - clr=1:
//    - in_ready=0 (no input accepted).
//    - An output transfer in that cycle still completes: out_valid was already registered.
//    - Next cycle: all v=0, d=RESET_VAL, count=0.
//  - clr together with rst: rst dominates. Reset mid-transfer discards all held items immediately.
// CONFIGURATION
//  Macro REGISTER_PIPE_SKID_EN:
//  - Defined:
//    - Every stage is a 2-entry skid buffer; its ready is registered (!skid_full), so there is no combinational path out_ready->in_ready.
//    - CAP=2*DEPTH. Latency and throughput unchanged.
//    - in_ready=0 during rst and the first cycle after rst deasserts.
//  - Undefined:
//    - Plain stages as above; in_ready depends combinationally on out_ready through DEPTH stages.
//    - CAP=DEPTH.
// STRUCTURE
//  - Package register_pkg:
//    - localparam function cap_f(depth, skid)
//    - typedef struct packed {logic v; logic [W-1:0] d;} used as stage_t via parametrised wrapper
//  - Sub-module register_pipe_stage (one stage; handshake in/out; skid variant under macro).
//    Instantiated DEPTH times in a generate loop. count is kept in top level.
// TESTING
//  1. Reset: rst pulse mid-cycle (async) -> out_valid=0, out_data=RESET_VAL, count=0 immediately, before next clk edge.
//  2. Stream: DEPTH=2, out_ready=1, feed 0x1..0xF back-to-back -> first out_valid after 2 cycles, 1 item/cycle, order preserved.
//  3. Backpressure: out_ready=0, feed 5 items -> count=CAP (2, or 4 with skid), in_ready=0. Release -> items out in order, count to 0.
//  4. Full+simultaneous: pipe full, in_valid=1, out_ready=1 -> one transfer each side, count stays CAP.
//  5. Flush: 2 items held, clr=1 with out_ready=1 -> head item delivered that cycle, in_ready=0; next cycle count=0, out_valid=0.
//  6. Random: random in_valid/out_ready for 10k cycles vs scoreboard queue -> no loss/dup/reorder, count==queue size every cycle.

Source files
------------

// File: rtl/register_pipe_pkg.sv
// Shared helpers for register_pipe: capacity/count-width math and the
// build-wide skid selection (macro REGISTER_PIPE_SKID_EN).
// The stage record {v, d} depends on WIDTH, so its typedef lives in the
// parametrised stage module rather than here.
package register_pkg;
`ifdef REGISTER_PIPE_SKID_EN
  localparam bit SKID_EN = 1'b1;
`else
  localparam bit SKID_EN = 1'b0;
`endif

  // Items the whole pipe can hold: one per stage, two per stage with skid.
  function automatic int cap_f(input int depth, input bit skid);
    return skid ? 2 * depth : depth;
  endfunction

  // Width of the occupancy counter; never wraps at CAP.
  function automatic int cw_f(input int depth);
    return $clog2(cap_f(depth, SKID_EN) + 1);
  endfunction
endpackage

// File: rtl/register_pipe_stage.sv
// One elastic register stage with valid/ready on both sides.
// Macro REGISTER_PIPE_SKID_EN selects a 2-entry skid stage whose ready is
// registered; otherwise a plain single register with combinational ready.
module register_pipe_stage
  import register_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             up_ready,
  output logic             dn_valid,
  output logic [WIDTH-1:0] dn_data,
  input  logic             dn_ready
);
  typedef struct packed {
    logic             v;
    logic [WIDTH-1:0] d;
  } stage_t;

  stage_t main_q, main_n;

`ifdef REGISTER_PIPE_SKID_EN
  stage_t skid_q, skid_n;
  logic   rdy_q;

  // Ready comes straight from a flop, cutting the out_ready->in_ready path.
  assign up_ready = rdy_q;

  // Next state: drain main (refilling from skid first), park overflow in skid.
  always_comb begin
    main_n = main_q;
    skid_n = skid_q;
    if (clr) begin
      main_n = {1'b0, RESET_VAL};
      skid_n = {1'b0, RESET_VAL};
    end else if (main_q.v && dn_ready) begin
      if (skid_q.v) begin
        main_n   = skid_q;
        skid_n.v = 1'b0;
      end else if (up_valid && rdy_q) begin
        main_n = {1'b1, up_data};
      end else begin
        main_n.v = 1'b0;
      end
    end else if (up_valid && rdy_q) begin
      if (!main_q.v) main_n = {1'b1, up_data};
      else           skid_n = {1'b1, up_data};
    end
  end

  // State registers; ready stays low through reset and the first cycle after.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= {1'b0, RESET_VAL};
      skid_q <= {1'b0, RESET_VAL};
      rdy_q  <= 1'b0;
    end else begin
      main_q <= main_n;
      skid_q <= skid_n;
      rdy_q  <= !skid_n.v;
    end
  end
`else
  // Ready when empty or when the stage ahead takes our item this cycle.
  assign up_ready = !main_q.v || dn_ready;

  // Next state: load on accept, go empty when our item leaves.
  always_comb begin
    main_n = main_q;
    if (clr)                       main_n = {1'b0, RESET_VAL};
    else if (up_ready && up_valid) main_n = {1'b1, up_data};
    else if (dn_ready)             main_n.v = 1'b0;
  end

  // Stage register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) main_q <= {1'b0, RESET_VAL};
    else     main_q <= main_n;
  end
`endif

  assign dn_valid = main_q.v;
  assign dn_data  = main_q.d;
endmodule

// File: rtl/register_pipe.sv
// DEPTH-stage elastic register pipeline with flush and occupancy count.
// Macro REGISTER_PIPE_SKID_EN: skid stages, CAP = 2*DEPTH, registered in_ready.
module register_pipe
  import register_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [cw_f(DEPTH)-1:0]    count
);
  localparam int CW = cw_f(DEPTH);

  logic in_fire, out_fire;

  // Chain of stages; stage 0 faces the input, stage DEPTH-1 drives the output.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stg
    logic             up_valid, up_ready, dn_valid, dn_ready;
    logic [WIDTH-1:0] up_data, dn_data;

    if (k == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_data  = in_data;
    end else begin : g_link
      assign up_valid = g_stg[k-1].dn_valid;
      assign up_data  = g_stg[k-1].dn_data;
    end

    if (k == DEPTH - 1) begin : g_tail
      assign dn_ready = out_ready;
    end else begin : g_next
      assign dn_ready = g_stg[k+1].up_ready;
    end

    register_pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .up_valid (up_valid),
      .up_data  (up_data),
      .up_ready (up_ready),
      .dn_valid (dn_valid),
      .dn_data  (dn_data),
      .dn_ready (dn_ready)
    );
  end

  // Flush blocks new input; an already-registered output may still leave.
  assign in_ready  = g_stg[0].up_ready && !clr;
  assign out_valid = g_stg[DEPTH-1].dn_valid;
  assign out_data  = g_stg[DEPTH-1].dn_data;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // Occupancy: +1 per input transfer, -1 per output transfer, cleared on flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       count <= '0;
    else if (clr)                  count <= '0;
    else if (in_fire && !out_fire) count <= count + CW'(1);
    else if (!in_fire && out_fire) count <= count - CW'(1);
  end
endmodule
